iter_shift_unit: RTL and testbench
==================================

Name: iter_shift_unit

Overview:
- Multi-cycle shift execution unit in the EX stage.
- Directly consumes the 32-bit zero-extended shift-amount operand produced by the shamt-extension stage, plus the rt register value.
- Shifts one bit per cycle under a start/busy/done handshake.
- Returns the result to the EX result mux; the pipeline stalls on busy.

Parameters:
- WIDTH, 32: datapath width of data_in and result.
- SHW, 5: number of low shamt_in bits used (log2 WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; accepted only in IDLE.
- op  input  2  shift operation: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
- data_in  input  WIDTH  operand to be shifted (rt value).
- shamt_in  input  32  zero-extended shift amount; only bits [SHW-1:0] are used.
- busy  output  1  high while an operation is in progress (SHIFT or DONE).
- done  output  1  one-cycle pulse; result is valid in that cycle.
- result  output  WIDTH  shifted value; holds until the next accepted start.

Behaviour:
- Reset, asynchronous and active-high: state=IDLE, result=0, cnt=0, op_r=00, busy=0, done=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On start: result<=data_in, op_r<=op, cnt<=shamt_in[SHW-1:0].
  - Next state is DONE if that amount is 0, else SHIFT.
  - Without start: all registers hold.
- SHIFT, one step per cycle:
  - SLL: result<={result[WIDTH-2:0],1'b0}.
  - SRL: result<={1'b0,result[WIDTH-1:1]}.
  - SRA: result<={result[WIDTH-1],result[WIDTH-1:1]}.
  - cnt<=cnt-1.
  - When cnt==1, go to DONE (this step is the final one).
- DONE: done=1 for exactly one cycle; result is stable; next state is IDLE.
- Latency: start sampled at edge 0 -> done high in cycle N+1, where N = shamt_in[4:0].
  - N=0 gives 1 cycle; N=31 gives 32 cycles.
  - Back-to-back throughput: a new start is accepted in the cycle after DONE.
- start while busy: ignored entirely. No queuing; operands are not re-sampled.
- shamt_in bits [31:SHW]: ignored. For example, 0xFFFFFFE3 shifts by 3.
- op=11 with the optional feature compiled out: behaves as SLL.
- Reset mid-operation: immediate return to IDLE with all outputs zero. The partial result is discarded.
- done and busy are registered state decodes, glitch-free: busy = (state!=IDLE), done = (state==DONE).
- cnt width is SHW; it never wraps because SHIFT is only entered with cnt>=1.

Optional Feature:
- Macro: SHIFT_ROTR_EN.
- Defined: op=11 selects ROTR, a rotate right by one per step: result<={result[0],result[WIDTH-1:1]}. Latency and handshake are identical to the other ops.
- Undefined: op=11 decodes as SLL, and no rotate logic is synthesized.

Decomposition:
- Package shift_pkg holds:
  - op encodings: OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROTR=2'b11.
  - FSM state encoding: S_IDLE, S_SHIFT, S_DONE (2 bits).
  - WIDTH and SHW defaults.
- One natural combinational sub-module, shift_step, computes the one-bit step from (op_r, result). The top level holds the FSM, counter and registers.

Test Plan:
- Reset check: assert rst mid-run at cycle 3 of a 10-bit SLL -> busy=0, done=0, result=0 immediately; a later start works normally.
- SLL: data_in=0x00000001, shamt_in=0x0000001F, start -> done in cycle 32, result=0x80000000, busy high in cycles 1-32.
- SRA vs SRL: data_in=0x80000000, shamt_in=4.
  - op=10 -> result=0xF8000000, done in cycle 5.
  - op=01 -> result=0x08000000.
- Zero amount: data_in=0x12345678, shamt_in=0 -> done in cycle 1, result=0x12345678.
- Upper bits ignored and start during busy: shamt_in=0xFFFFFFE3, SRL of 0x000000F0 -> result=0x0000001E in cycle 4. A second start pulsed in cycle 2 with different operands is ignored.
- Optional feature (SHIFT_ROTR_EN defined): op=11, data_in=0x00000003, shamt_in=1 -> result=0x80000001, done in cycle 2. Without the macro, the same stimulus gives result=0x00000006.

Source files
------------

// File: rtl/iter_shift_unit_pkg.sv
// Shared encodings and default sizes for the iterative shift unit.
package shift_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SHW   = 5;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/iter_shift_unit_step.sv
// One-bit shift step selected by the latched op.
// SHIFT_ROTR_EN adds rotate-right for op=11; otherwise op=11 falls back to SLL.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] next
);

  always_comb begin
    next = {data[WIDTH-2:0], 1'b0};
    case (op)
      OP_SRL:  next = {1'b0, data[WIDTH-1:1]};
      OP_SRA:  next = {data[WIDTH-1], data[WIDTH-1:1]};
`ifdef SHIFT_ROTR_EN
      OP_ROTR: next = {data[0], data[WIDTH-1:1]};
`endif
      default: next = {data[WIDTH-2:0], 1'b0};
    endcase
  end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter: one bit per cycle under a start/busy/done handshake.
// Optional macro SHIFT_ROTR_EN enables rotate-right on op=11.
module iter_shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SHW   = DEF_SHW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [31:0]      shamt_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_e           state;
  op_e              op_r;
  logic [SHW-1:0]   cnt;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] step_val;
  logic             unused_shamt_hi;

  assign amt             = shamt_in[SHW-1:0];
  assign unused_shamt_hi = ^shamt_in[31:SHW];

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op   (op_r),
    .data (result),
    .next (step_val)
  );

  // busy/done are updated alongside state so they equal its decode, registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      op_r   <= OP_SLL;
      cnt    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            result <= data_in;
            op_r   <= op_e'(op);
            cnt    <= amt;
            busy   <= 1'b1;
            if (amt == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          result <= step_val;
          cnt    <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed self-checking bench for iter_shift_unit (honours SHIFT_ROTR_EN).
module tb_iter_shift_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [31:0] shamt_in;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  iter_shift_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .data_in  (data_in),
    .shamt_in (shamt_in),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [31:0] shamt;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Pulse start at edge 0, then follow cycles 1..N+1; result must hold one cycle after done.
  task automatic run_op(input string name, input vec_t v);
    int  lat;
    bit  busy_ok;
    lat = -1;
    busy_ok = 1'b1;
    @(negedge clk);
    op = v.op; data_in = v.data; shamt_in = v.shamt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
    end
    check({name, " latency"}, lat, v.exp_lat);
    check({name, " result"}, result, v.exp_res);
    check({name, " busy in done"}, {31'b0, busy}, 32'd1);
    check({name, " busy while shifting"}, {31'b0, busy_ok}, 32'd1);
    @(posedge clk); #1;
    check({name, " done one cycle"}, {31'b0, done}, 32'd0);
    check({name, " idle after done"}, {31'b0, busy}, 32'd0);
    check({name, " result held"}, result, v.exp_res);
  endtask

  initial begin
    vec_t v;
    int   lat;

    vecs[0] = '{2'b00, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32};
    vecs[1] = '{2'b10, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 5};
    vecs[2] = '{2'b01, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 5};
    vecs[3] = '{2'b00, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1};
    vecs[4] = '{2'b01, 32'h0000_00F0, 32'hFFFF_FFE3, 32'h0000_001E, 4};
`ifdef SHIFT_ROTR_EN
    vecs[5] = '{2'b11, 32'h0000_0003, 32'h0000_0001, 32'h8000_0001, 2};
`else
    vecs[5] = '{2'b11, 32'h0000_0003, 32'h0000_0001, 32'h0000_0006, 2};
`endif
    vecs[6] = '{2'b00, 32'h0000_00A5, 32'h0000_0008, 32'h0000_A500, 9};
    vecs[7] = '{2'b10, 32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0000, 32};
    vecs[8] = '{2'b10, 32'hFFFF_0000, 32'h0000_0010, 32'hFFFF_FFFF, 17};
    vecs[9] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0020, 32'hFFFF_FFFF, 1};

    rst = 1'b1; start = 1'b0; op = 2'b00; data_in = '0; shamt_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset result", result, 32'h0);

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset in cycle 3 of a 10-bit SLL must clear everything without waiting for a clock.
    @(negedge clk);
    op = 2'b00; data_in = 32'h0000_0001; shamt_in = 32'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("mid-op busy before reset", {31'b0, busy}, 32'd1);
    check("mid-op partial result", result, 32'h0000_0004);
    rst = 1'b1;
    #1;
    check("async reset busy", {31'b0, busy}, 32'd0);
    check("async reset done", {31'b0, done}, 32'd0);
    check("async reset result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after reset", vecs[2]);

    // A start pulsed during busy must not disturb the operation in flight.
    @(negedge clk);
    op = 2'b01; data_in = 32'h0000_00F0; shamt_in = 32'hFFFF_FFE3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    op = 2'b00; data_in = 32'hFFFF_FFFF; shamt_in = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    #1;
    for (int c = 2; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c + 1;
        break;
      end
    end
    check("busy-start latency", lat, 4);
    check("busy-start result", result, 32'h0000_001E);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("busy-start not queued", {31'b0, busy}, 32'd0);
    check("busy-start result kept", result, 32'h0000_001E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
